// File: rtl/db_ram_pkg.sv
// Shared constants and grant encoding for the deblocking SRAM arbiter.
package db_ram_pkg;

  localparam int DB_WORD_WIDTH = 16;
  localparam int DB_ADDR_WIDTH = 8;
  localparam int DB_WBUF_DEPTH = 4;

  typedef enum logic [1:0] {
    GNT_IDLE = 2'd0,
    GNT_READ = 2'd1,
    GNT_BUF  = 2'd2,
    GNT_BYP  = 2'd3
  } gnt_t;

endpackage

// File: rtl/db_ram_wbuf.sv
// Circular write buffer; flags whether any stored entry targets the compare address.
module db_ram_wbuf
  import db_ram_pkg::*;
#(
  parameter int AW    = DB_ADDR_WIDTH,
  parameter int DW    = DB_WORD_WIDTH,
  parameter int DEPTH = DB_WBUF_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [AW-1:0]            push_addr,
  input  logic [DW-1:0]            push_dat,
  input  logic                     pop,
  input  logic [AW-1:0]            cmp_addr,
  output logic [AW-1:0]            head_addr,
  output logic [DW-1:0]            head_dat,
  output logic                     full,
  output logic                     empty,
  output logic                     hit,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);

  logic [AW-1:0] addr_q [DEPTH];
  logic [DW-1:0] dat_q  [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   cnt;
  logic [PW-1:0] off;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        dat_q[i]  <= '0;
      end
    end else begin
      if (push) begin
        addr_q[wr_ptr] <= push_addr;
        dat_q[wr_ptr]  <= push_dat;
        wr_ptr         <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // An entry is live when its distance from the head is below the fill count.
  always_comb begin
    hit = 1'b0;
    off = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off = PW'(i) - rd_ptr;
      if (({1'b0, off} < cnt) && (addr_q[i] == cmp_addr)) hit = 1'b1;
    end
  end

  assign head_addr = addr_q[rd_ptr];
  assign head_dat  = dat_q[rd_ptr];
  assign full      = (cnt == (PW+1)'(DEPTH));
  assign empty     = (cnt == '0);
  assign count     = cnt;

endmodule

// File: rtl/db_ram_1p_arb.sv
// Single-port SRAM arbiter: buffered writes, prioritised reads, read-after-write protection.
module db_ram_1p_arb
  import db_ram_pkg::*;
#(
  parameter int WORD_WIDTH = DB_WORD_WIDTH,
  parameter int ADDR_WIDTH = DB_ADDR_WIDTH,
  parameter int WBUF_DEPTH = DB_WBUF_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_val_i,
  input  logic [ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [WORD_WIDTH-1:0] wr_dat_i,
  output logic                  wr_rdy_o,
  input  logic                  rd_val_i,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  output logic                  rd_rdy_o,
  output logic                  rd_dat_val_o,
  output logic [WORD_WIDTH-1:0] rd_dat_o,
  output logic                  busy_o,
  output logic                  ram_cen_o,
  output logic                  ram_oen_o,
  output logic                  ram_wen_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic [WORD_WIDTH-1:0] ram_dat_o,
  input  logic [WORD_WIDTH-1:0] ram_dat_i
);

  gnt_t                      gnt;
  logic                      haz;
  logic                      push;
  logic                      pop;
  logic                      full;
  logic                      empty;
  logic                      hit;
  logic [ADDR_WIDTH-1:0]     head_addr;
  logic [WORD_WIDTH-1:0]     head_dat;
  logic [$clog2(WBUF_DEPTH):0] count;
  logic                      rd_p1;

  db_ram_wbuf #(
    .AW    (ADDR_WIDTH),
    .DW    (WORD_WIDTH),
    .DEPTH (WBUF_DEPTH)
  ) u_wbuf (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_addr (wr_addr_i),
    .push_dat  (wr_dat_i),
    .pop       (pop),
    .cmp_addr  (rd_addr_i),
    .head_addr (head_addr),
    .head_dat  (head_dat),
    .full      (full),
    .empty     (empty),
    .hit       (hit),
    .count     (count)
  );

  assign haz = rd_val_i & hit;

  // Grant is forced idle while reset is asserted so no SRAM access leaks out.
  always_comb begin
    gnt = GNT_IDLE;
    if (!rst_n)             gnt = GNT_IDLE;
    else if (haz || full)   gnt = GNT_BUF;
    else if (rd_val_i)      gnt = GNT_READ;
    else if (!empty)        gnt = GNT_BUF;
    else if (wr_val_i)      gnt = GNT_BYP;
  end

  assign rd_rdy_o = !(haz | full);
  assign wr_rdy_o = !full;
  assign push     = wr_val_i & !full & (gnt != GNT_BYP);
  assign pop      = (gnt == GNT_BUF);

  always_comb begin
    ram_cen_o  = 1'b1;
    ram_wen_o  = 1'b1;
    ram_addr_o = '0;
    ram_dat_o  = '0;
    case (gnt)
      GNT_READ: begin
        ram_cen_o  = 1'b0;
        ram_addr_o = rd_addr_i;
      end
      GNT_BUF: begin
        ram_cen_o  = 1'b0;
        ram_wen_o  = 1'b0;
        ram_addr_o = head_addr;
        ram_dat_o  = head_dat;
      end
      GNT_BYP: begin
        ram_cen_o  = 1'b0;
        ram_wen_o  = 1'b0;
        ram_addr_o = wr_addr_i;
        ram_dat_o  = wr_dat_i;
      end
      default: ;
    endcase
  end

  assign ram_oen_o = 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_p1        <= 1'b0;
      rd_dat_val_o <= 1'b0;
      rd_dat_o     <= '0;
    end else begin
      rd_p1        <= (gnt == GNT_READ);
      rd_dat_val_o <= rd_p1;
      if (rd_p1) rd_dat_o <= ram_dat_i;
    end
  end

  assign busy_o = (count != '0) | rd_p1 | rd_dat_val_o;

endmodule
